// File: rtl/switch_pkg.sv
// Shared definitions for the bouncy push-button stimulus generator.
package switch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PB   = 3'd1,
    HOLD = 3'd2,
    RB   = 3'd3,
    SET  = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/switch_bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR; supplies the bounce interval randomness.
module lfsr16
  import switch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= LFSR_SEED;
    else       q <= (q >> 1) ^ (q[0] ? LFSR_MASK : 16'h0000);
  end

endmodule

// File: rtl/switch_bounce_gen.sv
// Generates a bouncy switch waveform on raw: press bounces, stable hold,
// release bounces and a quiet settle period, then a one-cycle done pulse.
module switch_bounce_gen
  import switch_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int N_BOUNCE = 3,
  parameter int BW       = 6,
  parameter int SETTLE   = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             press,
  input  logic [CNT_W-1:0] hold_time,
  output logic             raw,
  output logic             busy,
  output logic             done
);

  localparam int TC_W = (N_BOUNCE > 0) ? $clog2(2*N_BOUNCE+1) : 1;
  localparam int SC_W = $clog2(SETTLE+1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(2*N_BOUNCE);
  localparam logic [SC_W-1:0] SC_INIT = SC_W'(SETTLE);

  logic [15:0]      lq;
  logic [CNT_W-1:0] ival, hold_sat;

  state_t           state, state_n;
  logic             raw_q, raw_n, done_q, done_n;
  logic [TC_W-1:0]  tc, tc_n;
  logic [CNT_W-1:0] ic, ic_n, hc, hc_n, hs, hs_n;
  logic [SC_W-1:0]  sc, sc_n;

  lfsr16 u_lfsr (.clock(clock), .reset(reset), .q(lq));

  assign ival     = CNT_W'({1'b0, lq[BW-1:0]}) + CNT_W'(1);
  assign hold_sat = (hold_time == '0) ? CNT_W'(1) : hold_time;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      raw_q  <= 1'b0;
      done_q <= 1'b0;
      tc     <= '0;
      ic     <= '0;
      hc     <= '0;
      hs     <= '0;
      sc     <= '0;
    end else begin
      state  <= state_n;
      raw_q  <= raw_n;
      done_q <= done_n;
      tc     <= tc_n;
      ic     <= ic_n;
      hc     <= hc_n;
      hs     <= hs_n;
      sc     <= sc_n;
    end
  end

  always_comb begin
    state_n = state;
    raw_n   = raw_q;
    done_n  = 1'b0;
    tc_n    = tc;
    ic_n    = ic;
    hc_n    = hc;
    hs_n    = hs;
    sc_n    = sc;
    case (state)
      IDLE: begin
        raw_n = 1'b0;
        if (press) begin
          hs_n  = hold_sat;
          raw_n = 1'b1;
          if (N_BOUNCE > 0) begin
            state_n = PB;
            tc_n    = '0;
            ic_n    = ival;
          end else begin
            state_n = HOLD;
            hc_n    = hold_sat;
          end
        end
      end
      // Bounce phases share logic; toggle count is even on exit so raw
      // already sits at the phase's settled level.
      PB, RB: begin
        if (ic == CNT_W'(1)) begin
          if (tc == TC_LAST) begin
            if (state == PB) begin
              state_n = HOLD;
              hc_n    = hs;
            end else begin
              state_n = SET;
              sc_n    = SC_INIT;
            end
          end else begin
            raw_n = ~raw_q;
            tc_n  = tc + TC_W'(1);
            ic_n  = ival;
          end
        end else begin
          ic_n = ic - CNT_W'(1);
        end
      end
      HOLD: begin
        if (hc == CNT_W'(1)) begin
          raw_n = 1'b0;
          if (N_BOUNCE > 0) begin
            state_n = RB;
            tc_n    = '0;
            ic_n    = ival;
          end else begin
            state_n = SET;
            sc_n    = SC_INIT;
          end
        end else begin
          hc_n = hc - CNT_W'(1);
        end
      end
      SET: begin
        raw_n = 1'b0;
        if (sc == SC_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          sc_n = sc - SC_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        raw_n   = 1'b0;
      end
    endcase
  end

  assign raw  = raw_q;
  assign busy = (state != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Self-checking bench: two generator instances (clean edge and bouncy) checked
// cycle by cycle against a segment-level waveform model built from a reference LFSR.
module tb_switch_bounce_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        press0 = 1'b0, press3 = 1'b0;
  logic [15:0] hold0 = '0, hold3 = '0;
  logic        raw0, busy0, done0, raw3, busy3, done3;
  int          checks = 0;
  int          errors = 0;
  int          ecnt;

  always #5 clock = ~clock;

  // Index of the last rising edge since reset was released.
  always @(posedge clock or posedge reset)
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;

  switch_bounce_gen #(.CNT_W(16), .N_BOUNCE(0), .BW(6), .SETTLE(4)) u0 (
    .clock(clock), .reset(reset), .press(press0), .hold_time(hold0),
    .raw(raw0), .busy(busy0), .done(done0));

  switch_bounce_gen #(.CNT_W(16), .N_BOUNCE(3), .BW(4), .SETTLE(8)) u3 (
    .clock(clock), .reset(reset), .press(press3), .hold_time(hold3),
    .raw(raw3), .busy(busy3), .done(done3));

  function automatic logic [15:0] lfsr_at(int n);
    logic [15:0] v = 16'hACE1;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  // Interval loaded at rising edge number e (register has advanced e-1 times).
  function automatic int ival_at(int e, int bw);
    return (int'(lfsr_at(e - 1)) % (1 << bw)) + 1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_press(input int d, input logic v);
    if (d == 0) press0 = v; else press3 = v;
  endtask

  // Entered and left on a falling edge; on exit we sit in the done cycle,
  // so a following call presses exactly in that cycle.
  task automatic burst(input int d, input logic [15:0] h, input bit spam);
    logic q[$];
    int   t, e, nb, bw, st, hs, len;
    logic r, b, dn;
    nb = (d == 0) ? 0 : 3;
    bw = (d == 0) ? 6 : 4;
    st = (d == 0) ? 4 : 8;
    hs = (h == 0) ? 1 : int'(h);
    if (d == 0) hold0 = h; else hold3 = h;
    drive_press(d, 1'b1);
    @(posedge clock);
    #1;
    t = ecnt;
    drive_press(d, 1'b0);
    e = t;
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k <= 2*nb && nb > 0; k++) begin
        len = ival_at(e, bw);
        if (len < 1 || len > (1 << bw)) check("ival_range", 1'b0, 1'b1);
        repeat (len) q.push_back((ph == 0) ? (k % 2 == 0) : (k % 2 == 1));
        e += len;
      end
      if (ph == 0) begin
        repeat (hs) q.push_back(1'b1);
        e += hs;
      end
    end
    repeat (st) q.push_back(1'b0);
    foreach (q[i]) begin
      @(negedge clock);
      r  = (d == 0) ? raw0  : raw3;
      b  = (d == 0) ? busy0 : busy3;
      dn = (d == 0) ? done0 : done3;
      check($sformatf("raw%0d[c%0d]", d, i), r, q[i]);
      check($sformatf("busy%0d[c%0d]", d, i), b, 1'b1);
      check($sformatf("done%0d[c%0d]", d, i), dn, 1'b0);
      drive_press(d, spam && ($urandom_range(0, 2) == 0));
    end
    @(negedge clock);
    drive_press(d, 1'b0);
    r  = (d == 0) ? raw0  : raw3;
    b  = (d == 0) ? busy0 : busy3;
    dn = (d == 0) ? done0 : done3;
    check($sformatf("raw%0d_done_cyc", d), r, 1'b0);
    check($sformatf("busy%0d_done_cyc", d), b, 1'b0);
    check($sformatf("done%0d_pulse", d), dn, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_raw0", raw0, 1'b0);   check("rst_busy0", busy0, 1'b0);
    check("rst_done0", done0, 1'b0); check("rst_raw3", raw3, 1'b0);
    check("rst_busy3", busy3, 1'b0); check("rst_done3", done3, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Clean edge: hold 10, settle 4; then zero hold treated as one.
    burst(0, 16'd10, 1'b0);
    repeat (2) @(negedge clock);
    check("idle_busy0", busy0, 1'b0);
    check("idle_done0", done0, 1'b0);
    burst(0, 16'd0, 1'b0);
    repeat (3) @(negedge clock);

    // Bouncy bursts with ignored presses while busy.
    for (int i = 0; i < 4; i++) begin
      burst(1, 16'($urandom_range(1, 40)), 1'b1);
      repeat ($urandom_range(1, 5)) @(negedge clock);
    end

    // Press in the done cycle is accepted immediately.
    burst(0, 16'($urandom_range(1, 20)), 1'b1);
    burst(0, 16'd5, 1'b0);
    burst(1, 16'd7, 1'b1);
    burst(1, 16'($urandom_range(1, 30)), 1'b0);
    repeat (2) @(negedge clock);

    // Asynchronous reset mid-press-bounce, then replay from the seed.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    hold3  = 16'd20;
    press3 = 1'b1;
    @(posedge clock);
    #1 press3 = 1'b0;
    @(negedge clock);
    check("mid_pb_busy3", busy3, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_raw3", raw3, 1'b0);
    check("async_busy3", busy3, 1'b0);
    check("async_done3", done3, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    burst(1, 16'd20, 1'b0);

    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clock);
      burst(0, 16'($urandom_range(0, 25)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
